tnn_feature_sequencer: RTL and testbench
========================================

// Module: tnn_feature_sequencer
// PURPOSE
//   Feeds the 2-bit-per-feature combinational TNN classifier neuron (7 inputs a..g, 1-bit out).
//   Accepts a serial stream of 2-bit feature codes over valid/ready and assembles one frame per
//   classification. Holds the assembled vector stable while the neuron settles, then samples
//   its 1-bit output. Returns class + frame-error over a valid/ready result port.
//   Sits between the feature-quantiser stream and the neuron instance; per-frame counters for debug.
// PARAMETERS
//   N_FEAT       7   features per frame (slot 0 = input_a ... slot 6 = input_g)
//   FEAT_W       2   bits per feature code
//   EVAL_CYCLES  1   cycles the vector is held before neuron_out is sampled (>=1)
//   CNT_W        16  width of frame statistics counters
// PORTS
//   clk         in   1               clock, all state on rising edge
//   rst_n       in   1               asynchronous active-low reset
//   s_valid     in   1               feature beat valid
//   s_ready     out  1               feature beat accepted when s_valid & s_ready
//   s_data      in   FEAT_W          feature code
//   s_last      in   1               marks final beat of a frame
//   feat_vec    out  N_FEAT*FEAT_W   to neuron; slot i on bits [FEAT_W*i +: FEAT_W]
//   neuron_out  in   1               neuron result (combinational from feat_vec)
//   m_valid     out  1               result valid
//   m_ready     in   1               result accepted when m_valid & m_ready
//   m_class     out  1               sampled neuron_out (0 on error frames)
//   m_err       out  1               frame length error
//   frames_ok   out  CNT_W           count of good frames, wraps at 2^CNT_W
//   frames_err  out  CNT_W           count of error frames, wraps at 2^CNT_W
// BEHAVIOUR
//   Reset: state=LOAD, idx=0, feat_vec=0, m_valid=0, m_class=0, m_err=0, counters=0, s_ready=1.
//   FSM states LOAD, DRAIN, EVAL, DONE. s_ready=1 only in LOAD and DRAIN; m_valid=1 only in DONE.
//   LOAD: each accepted beat writes s_data to slot idx, idx++.
//     - idx==N_FEAT-1 with s_last=1 -> EVAL, eval counter loaded with EVAL_CYCLES.
//     - idx==N_FEAT-1 with s_last=0 -> DRAIN (overlong frame).
//     - idx<N_FEAT-1 with s_last=1  -> DONE, m_err=1, m_class=0 (short frame).
//   DRAIN: accept and discard beats; feat_vec unchanged; accepted beat with s_last=1 -> DONE,
//     m_err=1, m_class=0.
//   EVAL: feat_vec frozen; counter decrements each cycle; on the cycle it reaches 0,
//     m_class<=neuron_out, m_err<=0 -> DONE. Latency last beat -> m_valid = EVAL_CYCLES+1 cycles.
//   DONE: m_class/m_err held stable while m_valid=1 and m_ready=0. On m_ready: -> LOAD,
//     idx=0, feat_vec cleared to 0, m_valid=0 next cycle. No beats accepted in DONE (backpressure).
//   Counters: frames_ok++ on entering DONE from EVAL; frames_err++ on entering DONE with m_err=1;
//     both wrap modulo 2^CNT_W with no saturation.
//   feat_vec is registered; only slot idx changes on a beat; other slots hold.
//   neuron_out is ignored outside the sampling cycle.
//   N_FEAT==1: first beat is also last slot; same rules apply.
//   Async reset mid-frame or mid-DONE aborts immediately to reset values; pending result lost,
//     counters cleared.
// TESTING
//   1 Frame a..g=1,0,1,1,1,1,1, last on 7th, neuron model, m_ready=1 -> feat_vec=14'h1551
//     during EVAL, m_valid 2 cycles after last beat, m_class=model(vec), m_err=0, frames_ok=1.
//   2 s_last on 4th beat -> m_valid with m_err=1, m_class=0, frames_err=1, frames_ok unchanged.
//   3 9-beat frame, s_last on 9th -> beats 8,9 accepted in DRAIN, m_err=1, slots hold beats 1-7.
//   4 m_ready low 10 cycles in DONE while s_valid=1 -> s_ready=0, m_class/m_err stable; after
//     accept, feat_vec=0, next frame loads normally; back-to-back frames with random s_valid gaps.
//   5 Preload frames_ok to 16'hFFFF (force) + one good frame -> wraps to 0.
//   6 rst_n low during beat 3 and again during EVAL -> all outputs to reset values next edge;
//     following full frame classifies correctly.

Source files
------------

// File: rtl/tnn_feature_sequencer_if.sv
// Bundles the feature stream, neuron link and result port of the feature sequencer.
// Latency: none, wires only.
// Backpressure: carries s_valid/s_ready on the feature side and m_valid/m_ready on the result side.
interface tnn_feature_sequencer_if #(
  parameter int N_FEAT = 7,
  parameter int FEAT_W = 2
);
  // feature stream from the quantiser
  logic                     s_valid;
  logic                     s_ready;
  logic [FEAT_W-1:0]        s_data;
  logic                     s_last;
  // link to the combinational neuron
  logic [N_FEAT*FEAT_W-1:0] feat_vec;
  logic                     neuron_out;
  // classification result
  logic                     m_valid;
  logic                     m_ready;
  logic                     m_class;
  logic                     m_err;

  // environment side: quantiser, neuron and result consumer
  modport master (
    output s_valid, s_data, s_last, m_ready, neuron_out,
    input  s_ready, feat_vec, m_valid, m_class, m_err
  );

  // sequencer side
  modport slave (
    input  s_valid, s_data, s_last, m_ready, neuron_out,
    output s_ready, feat_vec, m_valid, m_class, m_err
  );
endinterface

// File: rtl/tnn_feature_sequencer.sv
// Assembles N_FEAT serial feature codes into a frame, holds it on the neuron, returns class/error.
// Latency: last beat to m_valid is EVAL_CYCLES+1 cycles for good frames, 1 cycle for length errors.
// Backpressure: s_ready drops from frame completion until the result is taken via m_ready.
module tnn_feature_sequencer #(
  parameter int N_FEAT      = 7,
  parameter int FEAT_W      = 2,
  parameter int EVAL_CYCLES = 1,
  parameter int CNT_W       = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  tnn_feature_sequencer_if.slave bus,
  output logic [CNT_W-1:0]      o_frames_ok,
  output logic [CNT_W-1:0]      o_frames_err
);

  localparam int IDX_W  = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam int ECNT_W = $clog2(EVAL_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_EVAL  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [IDX_W-1:0]         r_idx;
  logic [N_FEAT*FEAT_W-1:0] r_feat_vec;
  logic [ECNT_W-1:0]        r_eval_cnt;
  logic                     r_m_class;
  logic                     r_m_err;
  logic [CNT_W-1:0]         r_frames_ok;
  logic [CNT_W-1:0]         r_frames_err;

  logic w_s_ready;
  logic w_m_valid;
  logic w_beat;
  logic w_last_slot;
  logic w_wr_slot;
  logic w_idx_inc;
  logic w_eval_load;
  logic w_eval_dec;
  logic w_sample;
  logic w_flag_err;
  logic w_clear;

  assign w_beat      = bus.s_valid & w_s_ready;
  assign w_last_slot = (r_idx == IDX_W'(N_FEAT - 1));

  // state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_LOAD;
    else          r_state <= w_state_nxt;
  end

  // next state, handshake outputs and datapath strobes
  always_comb begin
    w_state_nxt = r_state;
    w_s_ready   = 1'b0;
    w_m_valid   = 1'b0;
    w_wr_slot   = 1'b0;
    w_idx_inc   = 1'b0;
    w_eval_load = 1'b0;
    w_eval_dec  = 1'b0;
    w_sample    = 1'b0;
    w_flag_err  = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      ST_LOAD: begin
        w_s_ready = 1'b1;
        if (w_beat) begin
          w_wr_slot = 1'b1;
          if (w_last_slot) begin
            // frame is full: either it ends here or the tail must be swallowed
            if (bus.s_last) begin
              w_state_nxt = ST_EVAL;
              w_eval_load = 1'b1;
            end else begin
              w_state_nxt = ST_DRAIN;
            end
          end else begin
            w_idx_inc = 1'b1;
            if (bus.s_last) begin
              w_state_nxt = ST_DONE;
              w_flag_err  = 1'b1;
            end
          end
        end
      end
      ST_DRAIN: begin
        w_s_ready = 1'b1;
        if (w_beat && bus.s_last) begin
          w_state_nxt = ST_DONE;
          w_flag_err  = 1'b1;
        end
      end
      ST_EVAL: begin
        // a count of 1 means this is the last settle cycle: sample now
        if (r_eval_cnt == ECNT_W'(1)) begin
          w_state_nxt = ST_DONE;
          w_sample    = 1'b1;
        end else begin
          w_eval_dec = 1'b1;
        end
      end
      ST_DONE: begin
        w_m_valid = 1'b1;
        if (bus.m_ready) begin
          w_state_nxt = ST_LOAD;
          w_clear     = 1'b1;
        end
      end
      default: w_state_nxt = ST_LOAD;
    endcase
  end

  // slot index: advances per loaded beat, rewinds when the result is taken
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       r_idx <= '0;
    else if (w_clear)   r_idx <= '0;
    else if (w_idx_inc) r_idx <= r_idx + IDX_W'(1);
  end

  // feature vector: only the addressed slot is written, everything else holds
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_feat_vec <= '0;
    end else if (w_clear) begin
      r_feat_vec <= '0;
    end else if (w_wr_slot) begin
      for (int i = 0; i < N_FEAT; i++) begin
        if (r_idx == IDX_W'(i)) r_feat_vec[FEAT_W*i +: FEAT_W] <= bus.s_data;
      end
    end
  end

  // settle counter for the neuron evaluation window
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)         r_eval_cnt <= '0;
    else if (w_eval_load) r_eval_cnt <= ECNT_W'(EVAL_CYCLES);
    else if (w_eval_dec)  r_eval_cnt <= r_eval_cnt - ECNT_W'(1);
  end

  // result register: error frames force class 0, good frames capture the neuron
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_m_class <= 1'b0;
      r_m_err   <= 1'b0;
    end else if (w_flag_err) begin
      r_m_class <= 1'b0;
      r_m_err   <= 1'b1;
    end else if (w_sample) begin
      r_m_class <= bus.neuron_out;
      r_m_err   <= 1'b0;
    end
  end

  // frame statistics, free-running modulo 2^CNT_W
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_frames_ok  <= '0;
      r_frames_err <= '0;
    end else begin
      if (w_sample)   r_frames_ok  <= r_frames_ok + CNT_W'(1);
      if (w_flag_err) r_frames_err <= r_frames_err + CNT_W'(1);
    end
  end

  assign bus.s_ready   = w_s_ready;
  assign bus.m_valid   = w_m_valid;
  assign bus.feat_vec  = r_feat_vec;
  assign bus.m_class   = r_m_class;
  assign bus.m_err     = r_m_err;
  assign o_frames_ok   = r_frames_ok;
  assign o_frames_err  = r_frames_err;

endmodule

// File: tb/tb_tnn_feature_sequencer.sv
// Bench for tnn_feature_sequencer: directed frames, transaction-level result model, per-cycle compare.
// Latency: results are expected at a fixed cycle after the last accepted beat.
// Backpressure: the result sink can stall m_ready for a programmed number of cycles.
module tb_tnn_feature_sequencer;
  localparam int N_FEAT      = 7;
  localparam int FEAT_W      = 2;
  localparam int EVAL_CYCLES = 1;
  localparam int CNT_W       = 16;
  localparam int VW          = N_FEAT * FEAT_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [CNT_W-1:0] frames_ok;
  logic [CNT_W-1:0] frames_err;
  int               n_vec = 0;
  int               n_bad = 0;
  int               cyc = 0;

  tnn_feature_sequencer_if #(.N_FEAT(N_FEAT), .FEAT_W(FEAT_W)) bus();

  tnn_feature_sequencer #(
    .N_FEAT(N_FEAT), .FEAT_W(FEAT_W), .EVAL_CYCLES(EVAL_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .bus(bus),
    .o_frames_ok(frames_ok),
    .o_frames_err(frames_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Ternary neuron: code 01 = +1, 10 = -1, others 0; weights +1 except slots 1 and 4 (-1); fires on sum > 0.
  function automatic logic neuron(input logic [VW-1:0] v);
    int acc;
    acc = 0;
    for (int i = 0; i < N_FEAT; i++) begin
      logic [1:0] c;
      int x;
      c = v[FEAT_W*i +: FEAT_W];
      x = (c == 2'b01) ? 1 : ((c == 2'b10) ? -1 : 0);
      acc += ((i % 3) == 1) ? -x : x;
    end
    return acc > 0;
  endfunction

  assign bus.neuron_out = neuron(bus.feat_vec);

  typedef struct {
    logic          cls;
    logic          err;
    logic [VW-1:0] vec;
    int            due;
  } exp_t;

  exp_t             exp_q[$];
  exp_t             cur;
  bit               active = 1'b0;
  int               stall = 0;
  logic [CNT_W-1:0] mdl_ok = '0;
  logic [CNT_W-1:0] mdl_err = '0;
  logic [1:0]       fr[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Drive fr[0..n-1] as one frame (s_last on beat n), then queue the result the rules predict.
  task automatic send_frame(input int n, input bit gaps);
    exp_t e;
    int   k;
    int   guard;
    e.vec = '0;
    k = 0;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        int nidle;
        nidle = $urandom_range(0, 2);
        repeat (nidle) begin
          @(negedge clk);
          bus.s_valid = 1'b0;
        end
      end
      @(negedge clk);
      bus.s_valid = 1'b1;
      bus.s_data  = fr[i];
      bus.s_last  = (i == n - 1);
      guard = 0;
      while (!bus.s_ready && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 100) chk("beat_accept_timeout", 32'(bus.s_ready), 1);
      k = cyc;
      @(posedge clk);
      if (i < N_FEAT) e.vec[FEAT_W*i +: FEAT_W] = fr[i];
    end
    e.err = (n != N_FEAT);
    e.cls = e.err ? 1'b0 : neuron(e.vec);
    e.due = e.err ? k + 1 : k + EVAL_CYCLES + 1;
    exp_q.push_back(e);
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic wait_result(input string tag);
    int t;
    t = 0;
    while (!bus.m_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_m_valid"}, 32'(bus.m_valid), 1);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || active) && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk("pending_results", exp_q.size() + int'(active), 0);
  endtask

  // Compare process: every cycle, one time unit after the rising edge.
  initial begin
    bus.m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        chk("rst_m_valid",    32'(bus.m_valid),  0);
        chk("rst_s_ready",    32'(bus.s_ready),  1);
        chk("rst_feat_vec",   32'(bus.feat_vec), 0);
        chk("rst_m_class",    32'(bus.m_class),  0);
        chk("rst_m_err",      32'(bus.m_err),    0);
        chk("rst_frames_ok",  32'(frames_ok),    0);
        chk("rst_frames_err", 32'(frames_err),   0);
        exp_q.delete();
        active      = 1'b0;
        bus.m_ready = 1'b0;
        mdl_ok      = '0;
        mdl_err     = '0;
      end else begin
        if (active && bus.m_ready) begin
          active = 1'b0;
          chk("post_accept_m_valid",  32'(bus.m_valid),  0);
          chk("post_accept_feat_vec", 32'(bus.feat_vec), 0);
        end
        if (!active && bus.m_valid) begin
          if (exp_q.size() == 0) begin
            chk("spurious_m_valid", 32'(bus.m_valid), 0);
          end else begin
            cur    = exp_q.pop_front();
            active = 1'b1;
            chk("result_latency", cyc, cur.due);
            if (cur.err) mdl_err++;
            else         mdl_ok++;
          end
        end else if (!active && exp_q.size() > 0 && cyc > exp_q[0].due) begin
          chk("result_timeout", 32'(bus.m_valid), 1);
          void'(exp_q.pop_front());
        end
        if (active) begin
          chk("m_class",         32'(bus.m_class),  32'(cur.cls));
          chk("m_err",           32'(bus.m_err),    32'(cur.err));
          chk("done_feat_vec",   32'(bus.feat_vec), 32'(cur.vec));
          chk("done_s_ready_lo", 32'(bus.s_ready),  0);
        end
        chk("frames_ok",  32'(frames_ok),  32'(mdl_ok));
        chk("frames_err", 32'(frames_err), 32'(mdl_err));
        if (active && stall > 0) begin
          bus.m_ready = 1'b0;
          stall--;
        end else begin
          bus.m_ready = active;
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    int lens[6] = '{7, 7, 3, 7, 8, 7};
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    rst_n       = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1: a..g = 1,0,1,1,1,1,1 -> vector 14'h1551, neuron sum +4 -> class 1
    for (int i = 0; i < 7; i++) fr[i] = (i == 1) ? 2'd0 : 2'd1;
    send_frame(7, 1'b0);
    chk("t1_feat_vec_eval", 32'(bus.feat_vec), 32'h1551);
    chk("t1_m_valid_eval",  32'(bus.m_valid),  0);
    wait_result("t1");
    chk("t1_m_class",   32'(bus.m_class), 1);
    chk("t1_m_err",     32'(bus.m_err),   0);
    chk("t1_frames_ok", 32'(frames_ok),   1);

    // 2: short frame, last on 4th beat
    for (int i = 0; i < 4; i++) fr[i] = 2'($urandom_range(0, 3));
    send_frame(4, 1'b0);
    wait_result("t2");
    chk("t2_m_err",      32'(bus.m_err),   1);
    chk("t2_m_class",    32'(bus.m_class), 0);
    chk("t2_frames_err", 32'(frames_err),  1);
    chk("t2_frames_ok",  32'(frames_ok),   1);

    // 3: 9-beat frame 3,2,1,0,3,2,1,0,3 -> slots keep the first seven -> 14'h1B1B
    for (int i = 0; i < 9; i++) fr[i] = 2'(3 - (i % 4));
    send_frame(9, 1'b0);
    wait_result("t3");
    chk("t3_feat_vec",   32'(bus.feat_vec), 32'h1B1B);
    chk("t3_m_err",      32'(bus.m_err),    1);
    chk("t3_frames_err", 32'(frames_err),   2);

    // 4: result held 10 cycles with the next frame already waiting, then back-to-back frames with gaps
    wait_idle();
    stall = 10;
    for (int i = 0; i < 7; i++) fr[i] = 2'($urandom_range(0, 3));
    send_frame(7, 1'b0);
    for (int i = 0; i < 7; i++) fr[i] = 2'($urandom_range(0, 3));
    send_frame(7, 1'b1);
    foreach (lens[j]) begin
      for (int i = 0; i < lens[j]; i++) fr[i] = 2'($urandom_range(0, 3));
      send_frame(lens[j], 1'b1);
    end

    // 5: frames_ok preloaded to all-ones wraps to 0 on the next good frame
    wait_idle();
    @(negedge clk);
    force dut.r_frames_ok = '1;
    mdl_ok = '1;
    @(negedge clk);
    release dut.r_frames_ok;
    for (int i = 0; i < 7; i++) fr[i] = 2'($urandom_range(0, 3));
    send_frame(7, 1'b0);
    wait_result("t5");
    chk("t5_frames_ok_wrap", 32'(frames_ok), 0);

    // 6: reset during beat 3, then during EVAL, then a clean frame
    wait_idle();
    @(negedge clk);
    bus.s_valid = 1'b1; bus.s_data = 2'd1; bus.s_last = 1'b0;
    chk("t6_s_ready_b1", 32'(bus.s_ready), 1);
    @(negedge clk);
    bus.s_data = 2'd2;
    chk("t6_s_ready_b2", 32'(bus.s_ready), 1);
    @(negedge clk);
    bus.s_data = 2'd3;
    rst_n = 1'b0;
    #1;
    chk("t6_async_feat_vec", 32'(bus.feat_vec), 0);
    @(negedge clk);
    bus.s_valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) fr[i] = 2'b10;
    send_frame(7, 1'b0);
    chk("t6_in_eval_m_valid", 32'(bus.m_valid), 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) fr[i] = (i == 1) ? 2'd0 : 2'd1;
    send_frame(7, 1'b0);
    wait_result("t6");
    chk("t6_m_class",   32'(bus.m_class), 1);
    chk("t6_m_err",     32'(bus.m_err),   0);
    chk("t6_frames_ok", 32'(frames_ok),   1);
    wait_idle();

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at cycle %0d, expected completion", cyc);
    $fatal(1, "timeout");
  end
endmodule
